// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Holds the operation codes, the divider step count and the FSM state encoding.
package hilo_pkg;

    // Number of divider iterations. Must equal the 32-bit data width.
    localparam int unsigned DIV_STEPS = 32;
    localparam int unsigned CntW      = $clog2(DIV_STEPS);

    // Operation codes carried on HiLoOp
    localparam logic [2:0] OpNop   = 3'b000;
    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpMultu = 3'b010;
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpDivu  = 3'b100;
    localparam logic [2:0] OpMthi  = 3'b101;
    localparam logic [2:0] OpMtlo  = 3'b110;
    localparam logic [2:0] OpMadd  = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StFix
    } state_e;

endpackage

// File: rtl/udiv_step_core.sv
// Unsigned restoring divider, one quotient bit per enabled cycle.
// Ports:
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   load_i          capture dividend/divisor and clear the step counter
//   step_i          perform one restoring step
//   dividend_i      32-bit unsigned dividend
//   divisor_i       32-bit unsigned divisor
//   quot_o, rem_o   quotient and remainder (valid after DIV_STEPS steps)
//   last_step_o     high while the step counter is on the final step
module udiv_step_core
    import hilo_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o,
    output logic        last_step_o
);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rem_q, rem_d;
    logic [31:0]     quot_q, quot_d;
    logic [31:0]     div_q, div_d;

    // Partial remainder after shifting in the next dividend bit; needs 33 bits.
    logic [32:0] rem_shift;
    logic        fits;

    assign rem_shift = {rem_q, quot_q[31]};
    assign fits      = (rem_shift >= {1'b0, div_q});

    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quot_d = quot_q;
        div_d  = div_q;
        if (load_i) begin
            cnt_d  = '0;
            rem_d  = '0;
            quot_d = dividend_i;   // dividend bits shift out the top as quotient shifts in
            div_d  = divisor_i;
        end else if (step_i) begin
            cnt_d  = cnt_q + CntW'(1);
            // Difference is below the divisor, so it always fits back in 32 bits.
            rem_d  = fits ? 32'(rem_shift - {1'b0, div_q}) : rem_shift[31:0];
            quot_d = {quot_q[30:0], fits};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quot_q <= '0;
            div_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quot_q <= quot_d;
            div_q  <= div_d;
        end
    end

    assign quot_o      = quot_q;
    assign rem_o       = rem_q;
    assign last_step_o = (cnt_q == CntW'(DIV_STEPS - 1));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register unit: single-cycle MULT/MULTU/MADD/MTHI/MTLO and a 33-cycle iterative DIV/DIVU.
// Ports:
//   Clk, Rst_n   clock and asynchronous active-low reset
//   Start        issue HiLoOp this cycle (ignored while Busy or Abort)
//   HiLoOp       operation code (hilo_pkg)
//   A, B         rs / rt operands
//   Abort        cancel an in-flight divide; also drops a same-cycle Start
//   HiOut, LoOut HI and LO registers
//   Busy         divide in flight
//   Done         one-cycle pulse after a divide commits HI/LO
module hilo_muldiv_unit
    import hilo_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [2:0]  HiLoOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Abort,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        Busy,
    output logic        Done
);

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        sign_a_q, sign_a_d;   // remainder sign
    logic        neg_q, neg_d;         // quotient sign
    logic        dvz_q, dvz_d;         // divide by zero
    logic [31:0] raw_a_q, raw_a_d;

    logic        core_load, core_step, core_last;
    logic [31:0] core_quot, core_rem;
    logic [31:0] mag_a, mag_b;
    logic        is_signed_div;

    logic [63:0] prod_s, prod_u;

    // Low 64 bits of the extended product equal the exact signed/unsigned product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'b0, A} * {32'b0, B};

    assign is_signed_div = (HiLoOp == OpDiv);
    assign mag_a = (is_signed_div && A[31]) ? 32'(-A) : A;
    assign mag_b = (is_signed_div && B[31]) ? 32'(-B) : B;

    udiv_step_core u_core (
        .clk_i       (Clk),
        .rst_ni      (Rst_n),
        .load_i      (core_load),
        .step_i      (core_step),
        .dividend_i  (mag_a),
        .divisor_i   (mag_b),
        .quot_o      (core_quot),
        .rem_o       (core_rem),
        .last_step_o (core_last)
    );

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        sign_a_d  = sign_a_q;
        neg_d     = neg_q;
        dvz_d     = dvz_q;
        raw_a_d   = raw_a_q;
        core_load = 1'b0;
        core_step = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Start && !Abort) begin
                    case (HiLoOp)
                        OpMult:  {hi_d, lo_d} = prod_s;
                        OpMultu: {hi_d, lo_d} = prod_u;
                        OpMadd:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
                        OpMthi:  hi_d = A;
                        OpMtlo:  lo_d = A;
                        OpDiv, OpDivu: begin
                            state_d   = StDiv;
                            core_load = 1'b1;
                            sign_a_d  = is_signed_div & A[31];
                            neg_d     = is_signed_div & (A[31] ^ B[31]);
                            dvz_d     = (B == 32'd0);
                            raw_a_d   = A;
                        end
                        default: ;
                    endcase
                end
            end
            StDiv: begin
                if (Abort) begin
                    state_d = StIdle;
                end else begin
                    core_step = 1'b1;
                    if (core_last) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!Abort) begin
                    done_d = 1'b1;
                    if (dvz_q) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = raw_a_q;
                    end else begin
                        lo_d = neg_q ? 32'(-core_quot) : core_quot;
                        hi_d = sign_a_q ? 32'(-core_rem) : core_rem;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= StIdle;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            sign_a_q <= 1'b0;
            neg_q    <= 1'b0;
            dvz_q    <= 1'b0;
            raw_a_q  <= '0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            sign_a_q <= sign_a_d;
            neg_q    <= neg_d;
            dvz_q    <= dvz_d;
            raw_a_q  <= raw_a_d;
        end
    end

    assign HiOut = hi_q;
    assign LoOut = lo_q;
    assign Busy  = (state_q != StIdle);
    assign Done  = done_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit.
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic        abort;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    hilo_muldiv_unit dut (
        .Clk    (clk),
        .Rst_n  (rst_n),
        .Start  (start),
        .HiLoOp (op),
        .A      (a_s),
        .B      (b_s),
        .Abort  (abort),
        .HiOut  (hi),
        .LoOut  (lo),
        .Busy   (busy),
        .Done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a_s   = x;
        b_s   = y;
        tick();
        start = 1'b0;
        op    = OpNop;
    endtask

    // Issue a divide and check latency, Done pulse and result.
    task automatic run_div(input string tag, input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi);
        int n;
        issue(o, x, y);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            chk({tag, "_done_while_busy"}, 32'(done), 32'd0);
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'd33);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_lo"}, lo, exp_lo);
        chk({tag, "_hi"}, hi, exp_hi);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int dn;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = OpNop;
        a_s      = '0;
        b_s      = '0;
        abort    = 1'b0;

        tick();
        tick();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single-cycle ops
        issue(OpMult, 32'hFFFF_FFFD, 32'd7);
        chk("mult_busy", 32'(busy), 32'd0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);

        issue(OpMultu, 32'hFFFF_FFFF, 32'd2);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        issue(OpMthi, 32'd0, 32'd0);
        chk("mthi_hi", hi, 32'd0);
        chk("mthi_lo_kept", lo, 32'hFFFF_FFFE);
        issue(OpMtlo, 32'd1, 32'd0);
        chk("mtlo_lo", lo, 32'd1);
        chk("mtlo_hi_kept", hi, 32'd0);
        issue(OpMadd, 32'd2, 32'd3);
        chk("madd_hi", hi, 32'd0);
        chk("madd_lo", lo, 32'd7);

        // Divides
        run_div("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("divu", OpDivu, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1);
        run_div("divu_zero", OpDivu, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        run_div("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);

        // Start while busy is ignored, then abort discards the divide
        issue(OpDiv, 32'd100, 32'd7);
        repeat (4) tick();
        issue(OpMult, 32'd3, 32'd3);
        chk("ign_busy", 32'(busy), 32'd1);
        chk("ign_lo", lo, 32'h8000_0000);
        chk("ign_hi", hi, 32'd0);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        dn = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        chk("abort_lo", lo, 32'h8000_0000);
        chk("abort_hi", hi, 32'd0);

        // Abort beats Start from idle
        abort = 1'b1;
        issue(OpMtlo, 32'd55, 32'd0);
        abort = 1'b0;
        chk("abort_start_lo", lo, 32'h8000_0000);
        chk("abort_start_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-divide
        issue(OpDiv, 32'd1000, 32'd3);
        repeat (19) tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_div("divu_post", OpDivu, 32'd9, 32'd3, 32'd3, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
